// File: rtl/ltc2324_acq_pkg.sv
// Shared types and constants for the LTC2324 acquisition sequencer.
// The optional latch-timeout feature is controlled by ACQ_LATCH_TIMEOUT_EN.
package ltc2324_acq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned NCH_DEF      = 4;
  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned LATCH_OFFSET = 78;
  localparam int unsigned MIN_PERIOD   = 80;

  // Channel index width, never narrower than one bit.
  function automatic int unsigned chan_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ltc2324_acq_serializer.sv
// Holding register plus word-at-a-time valid/ready streamer for one captured sample.
module ltc2324_acq_serializer
  import ltc2324_acq_pkg::*;
#(
  parameter int unsigned NCH    = NCH_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   capture,
  input  logic [NCH*DATA_W-1:0]  ch_data,
  input  logic                   cap_last,
  input  logic                   hold_last,
  input  logic                   m_ready,
  output logic                   m_valid,
  output logic [DATA_W-1:0]      m_data,
  output logic [chan_w(NCH)-1:0] m_chan,
  output logic                   m_last,
  output logic                   full,
  output logic                   dropped_c
);

  localparam int unsigned CW = chan_w(NCH);

  logic [DATA_W-1:0] hold_q [NCH];
  logic              full_q;
  logic              tag_q;
  logic [CW-1:0]     idx_q;
  logic [CW-1:0]     nxt_c;
  logic              hs_c;
  logic              last_hs_c;
  logic              accept_c;

  assign nxt_c     = idx_q + CW'(1);
  assign hs_c      = m_valid && m_ready;
  assign last_hs_c = hs_c && (idx_q == CW'(NCH - 1));
  // The register frees on the final handshake, so a latch in that cycle still fits.
  assign accept_c  = capture && (!full_q || last_hs_c);
  assign dropped_c = capture && !accept_c;
  assign full      = full_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) hold_q[i] <= '0;
      full_q  <= 1'b0;
      tag_q   <= 1'b0;
      idx_q   <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_chan  <= '0;
      m_last  <= 1'b0;
    end else if (flush) begin
      full_q  <= 1'b0;
      tag_q   <= 1'b0;
      idx_q   <= '0;
      m_valid <= 1'b0;
      m_chan  <= '0;
      m_last  <= 1'b0;
    end else if (accept_c) begin
      for (int i = 0; i < NCH; i++) hold_q[i] <= ch_data[i*DATA_W +: DATA_W];
      full_q  <= 1'b1;
      tag_q   <= cap_last;
      idx_q   <= '0;
      m_valid <= 1'b1;
      m_data  <= ch_data[DATA_W-1:0];
      m_chan  <= '0;
      m_last  <= (NCH == 1) && cap_last;
    end else if (last_hs_c) begin
      full_q  <= 1'b0;
      idx_q   <= '0;
      m_valid <= 1'b0;
      m_chan  <= '0;
      m_last  <= 1'b0;
    end else if (hs_c) begin
      idx_q  <= nxt_c;
      m_data <= hold_q[nxt_c];
      m_chan <= nxt_c;
      m_last <= (nxt_c == CW'(NCH - 1)) && (tag_q || hold_last);
    end
  end

endmodule

// File: rtl/ltc2324_acq_sequencer.sv
// LTC2324 acquisition controller: sync pacing, burst counting and sample streaming.
// Build with ACQ_LATCH_TIMEOUT_EN defined to enable the missing-latch timeout.
module ltc2324_acq_sequencer
  import ltc2324_acq_pkg::*;
#(
  parameter int unsigned CLK_PER_SAMPLE = 100,
  parameter int unsigned BURST_W        = 16,
  parameter int unsigned NCH            = NCH_DEF,
  parameter int unsigned DATA_W         = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [BURST_W-1:0]     burst_len,
  output logic                   sync,
  input  logic                   data_latch,
  input  logic [NCH*DATA_W-1:0]  ch_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_W-1:0]      m_data,
  output logic [chan_w(NCH)-1:0] m_chan,
  output logic                   m_last,
  output logic                   busy,
  output logic                   overrun,
  input  logic                   clr_overrun,
  output logic                   err_timeout
);

  localparam int unsigned PW = $clog2(CLK_PER_SAMPLE);
  localparam logic [PW-1:0] RELOAD = PW'(CLK_PER_SAMPLE - 1);

  state_t             state_q, state_d;
  logic [PW-1:0]      period_q, period_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic [BURST_W-1:0] issued_q, issued_d;
  logic [BURST_W-1:0] samples_q, samples_d;
  logic [BURST_W-1:0] samp_next_c;
  logic               stop_pend_q, stop_pend_d;
  logic               sync_q, sync_d;
  logic               busy_q;
  logic               latch_d1_q;
  logic               overrun_q;
  logic               latch_rise_c;
  logic               capture_c;
  logic               cap_last_c;
  logic               hold_last_c;
  logic               flush_c;
  logic               ser_full;
  logic               dropped_c;
`ifdef ACQ_LATCH_TIMEOUT_EN
  logic               err_q, err_d;
`endif

  assign latch_rise_c = data_latch && !latch_d1_q;
  assign capture_c    = latch_rise_c && (state_q != IDLE);
  assign samp_next_c  = samples_q + BURST_W'(1);
  // A sample is final if it completes a finite burst, or is the last one owed after a stop.
  assign cap_last_c   = ((len_q != '0) && (samp_next_c == len_q)) ||
                        (stop_pend_q && (samp_next_c == issued_q));
  assign hold_last_c  = stop_pend_q && (samples_q == issued_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      period_q    <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      samples_q   <= '0;
      stop_pend_q <= 1'b0;
      sync_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ACQ_LATCH_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      samples_q   <= samples_d;
      stop_pend_q <= stop_pend_d;
      sync_q      <= sync_d;
      busy_q      <= (state_d != IDLE);
`ifdef ACQ_LATCH_TIMEOUT_EN
      err_q       <= err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    len_d       = len_q;
    issued_d    = issued_q;
    samples_d   = samples_q;
    stop_pend_d = stop_pend_q;
    sync_d      = 1'b0;
    flush_c     = 1'b0;
`ifdef ACQ_LATCH_TIMEOUT_EN
    err_d       = err_q;
`endif
    if (capture_c) samples_d = samp_next_c;

    unique case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (start && !stop) begin
          state_d   = RUN;
          len_d     = burst_len;
          issued_d  = BURST_W'(1);
          samples_d = '0;
          sync_d    = 1'b1;
          period_d  = RELOAD;
`ifdef ACQ_LATCH_TIMEOUT_EN
          err_d     = 1'b0;
`endif
        end
      end
      RUN: begin
        if (stop) stop_pend_d = 1'b1;
        if (period_q == '0) begin
          period_d = RELOAD;
`ifdef ACQ_LATCH_TIMEOUT_EN
          if (issued_q != samples_d) begin
            err_d   = 1'b1;
            flush_c = 1'b1;
            state_d = IDLE;
          end else
`endif
          if (((len_q != '0) && (issued_q == len_q)) || stop_pend_q || stop) begin
            state_d = DRAIN;
          end else begin
            sync_d   = 1'b1;
            issued_d = issued_q + BURST_W'(1);
          end
        end else begin
          period_d = period_q - PW'(1);
        end
      end
      DRAIN: begin
        period_d = (period_q == '0) ? RELOAD : period_q - PW'(1);
`ifdef ACQ_LATCH_TIMEOUT_EN
        if ((period_q == '0) && (issued_q != samples_d)) begin
          err_d   = 1'b1;
          flush_c = 1'b1;
          state_d = IDLE;
        end else
`endif
        if ((samples_q == issued_q) && !ser_full) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Rising-edge history for data_latch and the sticky overrun flag (set wins over clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_d1_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      latch_d1_q <= data_latch;
      if (dropped_c)        overrun_q <= 1'b1;
      else if (clr_overrun) overrun_q <= 1'b0;
    end
  end

  ltc2324_acq_serializer #(
    .NCH    (NCH),
    .DATA_W (DATA_W)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush_c),
    .capture   (capture_c),
    .ch_data   (ch_data),
    .cap_last  (cap_last_c),
    .hold_last (hold_last_c),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_chan    (m_chan),
    .m_last    (m_last),
    .full      (ser_full),
    .dropped_c (dropped_c)
  );

  assign sync    = sync_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;
`ifdef ACQ_LATCH_TIMEOUT_EN
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ltc2324_acq_sequencer.sv
// Directed, table-driven bench for ltc2324_acq_sequencer with a simple latch-strobe model.
module tb_ltc2324_acq_sequencer;
  import ltc2324_acq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, sync, data_latch, m_valid, m_ready, m_last;
  logic        busy, overrun, clr_overrun, err_timeout;
  logic [15:0] burst_len;
  logic [63:0] ch_data;
  logic [15:0] m_data;
  logic [1:0]  m_chan;

  ltc2324_acq_sequencer dut (
    .clk (clk), .rst_n (rst_n), .start (start), .stop (stop), .burst_len (burst_len),
    .sync (sync), .data_latch (data_latch), .ch_data (ch_data), .m_valid (m_valid),
    .m_ready (m_ready), .m_data (m_data), .m_chan (m_chan), .m_last (m_last),
    .busy (busy), .overrun (overrun), .clr_overrun (clr_overrun), .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] data; logic [1:0] chan; logic last; } word_t;
  typedef struct {
    logic [15:0] len;
    logic [63:0] data;
    int          exp_syncs;
    int          exp_words;
    logic [15:0] exp_w0;
    logic [15:0] exp_w3;
  } vec_t;

  word_t wq[$];
  int    sq[$];
  int    cyc = 0, t0 = 0;
  int    checks = 0, errors = 0;
  logic  latch_en = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  // Records the handshake that the coming edge performs, then advances one cycle.
  task automatic step();
    word_t w;
    if (m_valid && m_ready) begin
      w.data = m_data; w.chan = m_chan; w.last = m_last;
      wq.push_back(w);
    end
    @(posedge clk); #1;
    cyc++;
    if (sync) sq.push_back(cyc - t0);
  endtask

  task automatic clear();
    wq.delete(); sq.delete(); t0 = cyc;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin step(); n++; end
  endtask

  task automatic chk_words(input string name, input logic [63:0] d, input int exp_n);
    chk({name, "_count"}, 64'(wq.size()), 64'(exp_n));
    for (int k = 0; k < wq.size() && k < exp_n; k++) begin
      chk({name, "_chan"}, 64'(wq[k].chan), 64'(k % 4));
      chk({name, "_data"}, 64'(wq[k].data), 64'(d[(k % 4)*16 +: 16]));
    end
  endtask

  // Latch strobe model: one-cycle data_latch LATCH_OFFSET cycles after each sync.
  initial begin
    int lat_cnt;
    lat_cnt = 0;
    data_latch = 1'b0;
    forever begin
      @(posedge clk); #1;
      data_latch = 1'b0;
      if (lat_cnt != 0) begin
        lat_cnt--;
        if (lat_cnt == 0) data_latch = latch_en;
      end
      if (sync) lat_cnt = int'(LATCH_OFFSET);
    end
  end

  initial begin
    vec_t        vec[3];
    logic [63:0] d, d2;
    int          s2, lastn;

    vec[0] = '{16'd3, 64'h4444_3333_2222_1111, 3, 12, 16'h1111, 16'h4444};
    vec[1] = '{16'd1, 64'hDEAD_BEEF_0123_89AB, 1, 4,  16'h89AB, 16'hDEAD};
    vec[2] = '{16'd2, 64'h0004_0003_0002_0001, 2, 8,  16'h0001, 16'h0004};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; burst_len = '0; ch_data = '0;
    m_ready = 1'b0; clr_overrun = 1'b0;
    repeat (3) step();
    chk("reset_outputs", {sync, m_valid, m_last, busy, overrun, err_timeout, m_data, m_chan}, 0);
    rst_n = 1'b1;
    step();

    // Finite bursts from the vector table
    for (int v = 0; v < 3; v++) begin
      clear();
      burst_len = vec[v].len; ch_data = vec[v].data; m_ready = 1'b1;
      start = 1'b1; step(); start = 1'b0;
      chk("busy_after_start", busy, 1);
      wait_idle(600);
      chk("burst_busy_end", busy, 0);
      chk("sync_count", 64'(sq.size()), 64'(vec[v].exp_syncs));
      for (int k = 0; k < sq.size(); k++) chk("sync_time", 64'(sq[k]), 64'(1 + 100*k));
      chk_words("burst", vec[v].data, vec[v].exp_words);
      if (wq.size() >= 4) begin
        chk("word0", wq[0].data, vec[v].exp_w0);
        chk("word3", wq[3].data, vec[v].exp_w3);
      end
      for (int k = 0; k < wq.size(); k++) chk("m_last_pos", wq[k].last, k == wq.size() - 1);
    end

    // Backpressure: second latch dropped, first sample kept intact
    clear();
    d = 64'hA003_A002_A001_A000; d2 = 64'hB003_B002_B001_B000;
    burst_len = 16'd2; ch_data = d; m_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 190; i++) begin
      if (i == 120) ch_data = d2;
      step();
    end
    chk("overrun_set", overrun, 1);
    chk("stalled_word", {m_valid, m_chan, m_data}, {1'b1, 2'd0, 16'hA000});
    m_ready = 1'b1;
    wait_idle(400);
    chk("bp_busy_end", busy, 0);
    chk_words("bp", d, 4);
    chk("overrun_sticky", overrun, 1);
    clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
    chk("overrun_cleared", overrun, 0);

    // Stop mid-period in continuous mode
    clear();
    d = 64'h7777_6666_5555_0F0F;
    burst_len = 16'd0; ch_data = d; m_ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    repeat (40) step();
    stop = 1'b1; step(); stop = 1'b0;
    wait_idle(300);
    chk("stop_busy_end", busy, 0);
    chk("stop_sync_count", 64'(sq.size()), 1);
    chk_words("stop", d, 4);
    if (wq.size() == 4) chk("stop_last", {wq[0].last, wq[1].last, wq[2].last, wq[3].last}, 4'b0001);

    // start and stop together in IDLE
    clear();
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    repeat (5) step();
    chk("startstop_sync", 64'(sq.size()), 0);
    chk("startstop_busy", busy, 0);

    // Latch on the same edge as the final word handshake
    clear();
    d = 64'hC3C3_C2C2_C1C1_C0C0;
    burst_len = 16'd2; ch_data = d; m_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int n = 0; n < 150 && sq.size() < 2; n++) step();
    chk("coinc_second_sync", 64'(sq.size()), 2);
    s2 = (sq.size() == 2) ? sq[1] : 101;
    for (int n = 0; n < 150 && (cyc - t0) < s2 + 75; n++) step();
    m_ready = 1'b1;
    wait_idle(300);
    chk("coinc_overrun", overrun, 0);
    chk_words("coinc", d, 8);
    lastn = 0;
    for (int k = 0; k < wq.size(); k++) if (wq[k].last) lastn++;
    chk("coinc_last_count", 64'(lastn), 1);
    if (wq.size() == 8) chk("coinc_last_pos", wq[7].last, 1);

    // Asynchronous reset in the middle of a stream
    clear();
    burst_len = 16'd0; ch_data = 64'h1234_5678_9ABC_DEF0; m_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int n = 0; n < 200 && !m_valid; n++) step();
    chk("pre_reset_valid", m_valid, 1);
    rst_n = 1'b0; #1;
    chk("async_reset", {sync, m_valid, m_last, busy, overrun, err_timeout, m_data, m_chan}, 0);
    step(); rst_n = 1'b1;
    repeat (3) step();
    chk("post_reset_idle", {busy, m_valid}, 0);

`ifdef ACQ_LATCH_TIMEOUT_EN
    // Missing latch: timeout aborts the run one period after the sync
    clear();
    latch_en = 1'b0; burst_len = 16'd0; m_ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    repeat (99) step();
    chk("to_busy_before", {busy, err_timeout}, 2'b10);
    step();
    chk("to_flag", err_timeout, 1);
    chk("to_busy_after", busy, 0);
    latch_en = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    chk("to_clear_on_start", err_timeout, 0);
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
`else
    chk("err_tied_low", err_timeout, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
